pico_spi_slave_rx: RTL and testbench
====================================

// Module: pico_spi_slave_rx
// PURPOSE
//  SPI mode-0 slave front-end for the RP2040 link. Synchronises pico_sck/pico_cs/pico_mosi into clk,
//  deserialises MSB-first bytes, serialises a response byte stream on MISO, and emits frame delimiters.
//  Sits directly upstream of spi_bridge, which consumes its byte stream to drive flash_cs/flash_mosi.
// PARAMETERS
//  SYNC_STAGES  2      flops per synchroniser chain (>=2)
//  IDX_W        16     width of in-frame byte index; saturates at all-ones
//  DEFAULT_TX   8'hFF  byte shifted out when no tx byte is pending (underrun)
// PORTS
//  clk          in   1      system clock, 100 MHz
//  rst          in   1      asynchronous, active-high reset
//  pico_sck     in   1      RP2040 SPI clock (async to clk)
//  pico_cs      in   1      RP2040 chip select, active low (async)
//  pico_mosi    in   1      RP2040 MOSI (async)
//  pico_miso    out  1      slave MISO toward RP2040
//  rx_data      out  8      last complete received byte
//  rx_valid     out  1      1-cycle strobe, rx_data/rx_idx valid
//  rx_idx       out  IDX_W  index of rx_data within frame (0 = first byte)
//  frame_start  out  1      1-cycle strobe on synchronised CS falling edge
//  frame_end    out  1      1-cycle strobe on synchronised CS rising edge
//  frame_abort  out  1      valid with frame_end: 1 if CS rose with a partial byte (bit_cnt != 0)
//  tx_data      in   8      next response byte
//  tx_valid     in   1      tx_data valid; accepted when tx_valid && tx_ready
//  tx_ready     out  1      one-entry holding register empty
//  tx_underrun  out  1      1-cycle strobe: DEFAULT_TX loaded because holding register empty
// BEHAVIOUR
//  - Reset values: pico_miso=0, rx_data=0, rx_valid=0, rx_idx=0, frame_start/end/abort=0,
//    tx_ready=1, tx_underrun=0; state=WAIT_IDLE; holding register cleared.
//  - Sync: each async input through SYNC_STAGES flops; sck/cs edges from sync'd value vs previous.
//    Input-to-edge latency SYNC_STAGES+1 clk. Supported pico_sck <= clk/8; slower OK, faster undefined.
//  - States: WAIT_IDLE -> IDLE when sync'd cs==1 (prevents joining a frame mid-stream after reset).
//    IDLE -> ACTIVE on cs fall: frame_start=1, bit_cnt=0, rx_idx counter=0, tx shift loads next byte.
//    ACTIVE -> IDLE on cs rise: frame_end=1, frame_abort=(bit_cnt!=0); partial byte discarded, no rx_valid.
//  - RX: on sck rise in ACTIVE, rx_shift={rx_shift[6:0],mosi}, bit_cnt++ (3-bit wrap). When bit_cnt
//    wraps 7->0, next cycle rx_data=completed byte, rx_valid=1, rx_idx=byte count; counter then +1,
//    saturating at 2^IDX_W-1. No backpressure: consumer must accept every rx_valid.
//  - TX: pico_miso=tx_shift[7] while ACTIVE, 0 otherwise. On sck fall in ACTIVE: if bit_cnt==0 load
//    next byte, else shift left by 1. "Load next byte": holding reg if full (then tx_ready=1 next cycle),
//    else DEFAULT_TX with tx_underrun=1.
//  - Holding reg write: tx_valid&&tx_ready captures tx_data, tx_ready=0 next cycle. Write and load in same
//    cycle: load takes old contents (if full) or DEFAULT_TX; the write lands in the now-empty register.
//  - Simultaneous cs rise and sck edge in one clk: cs wins, sck edge ignored.
//  - frame_start and frame_end never same cycle; rx_valid may coincide with frame_end (last byte) —
//    rx_valid asserted first in that cycle order; consumer sees both.
//  - Holding register persists across frames (pre-loaded response for next frame allowed).
//  - Async rst mid-frame: all outputs to reset values immediately; WAIT_IDLE until cs high.
// STRUCTURE
//  - Package pico_spi_pkg: SPI_BYTE_W=8, typedef logic [7:0] spi_byte_t, typedef enum
//    {WAIT_IDLE, IDLE, ACTIVE} spi_slv_state_t; shared with spi_bridge.
//  - Sub-module spi_sync_edge (SYNC_STAGES param; outputs level, rise, fall), one instance each for
//    pico_sck and pico_cs; pico_mosi uses level output only. Rest is a single always_ff FSM + datapath.
// TESTING
//  1 Reset with cs=0 and toggling sck, release rst -> no frame_start/rx_valid until cs high then low.
//  2 cs low, send 8'hA5, 8'h3C at clk/10 -> rx_valid twice: (A5,idx0),(3C,idx1); frame_end, abort=0.
//  3 Pre-load tx 8'h9F, then 8'h01 on first ready -> MISO bits 10011111 00000001; next byte FF + underrun.
//  4 cs rises after 5 bits of 8'hFF -> frame_end=1, frame_abort=1, no rx_valid; next frame idx restarts 0.
//  5 Assert rst after 3 bits of byte 2 -> outputs reset immediately; new frame after cs cycle gets idx0.
//  6 260-byte frame with IDX_W=8 -> rx_idx counts 0..255 then holds 255; all 260 bytes match stimulus.

Source files
------------

// File: rtl/pico_spi_pkg.sv
// Shared types for the RP2040 SPI link (slave front-end and spi_bridge).
package pico_spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;

   typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE
   } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with edge strobes
// derived from the synchronised level against its previous value.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/pico_spi_slave_rx.sv
// SPI mode-0 slave front-end: synchronises the RP2040 pins, deserialises
// MSB-first bytes, serialises the response stream and flags frame edges.
module pico_spi_slave_rx
   import pico_spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned IDX_W       = 16,
   parameter spi_byte_t   DEFAULT_TX  = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pico_sck,
   input  logic             pico_cs,
   input  logic             pico_mosi,
   output logic             pico_miso,
   output spi_byte_t        rx_data,
   output logic             rx_valid,
   output logic [IDX_W-1:0] rx_idx,
   output logic             frame_start,
   output logic             frame_end,
   output logic             frame_abort,
   input  spi_byte_t        tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun
);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic mosi_lvl;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk(clk), .rst(rst), .din(pico_sck),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk(clk), .rst(rst), .din(pico_cs),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   // MOSI needs only a level, delayed to match the sck chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_sync <= '0;
      else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pico_mosi};
   end
   assign mosi_lvl = mosi_sync[SYNC_STAGES-1];

   spi_slv_state_t   state_q, state_d;
   logic [2:0]       bit_cnt;
   spi_byte_t        rx_shift, tx_shift, hold_data;
   logic             hold_full;
   logic [IDX_W-1:0] idx_cnt;
   logic             do_start, do_end, do_rx, do_load, do_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= WAIT_IDLE;
      else     state_q <= state_d;
   end

   // A cs rise masks any sck edge seen in the same cycle.
   always_comb begin
      state_d  = state_q;
      do_start = 1'b0;
      do_end   = 1'b0;
      do_rx    = 1'b0;
      do_load  = 1'b0;
      do_shift = 1'b0;
      unique case (state_q)
         WAIT_IDLE: if (cs_lvl) state_d = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_d  = ACTIVE;
               do_start = 1'b1;
               do_load  = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
               do_end  = 1'b1;
            end else begin
               do_rx = sck_rise;
               if (sck_fall) begin
                  if (bit_cnt == 3'd0) do_load  = 1'b1;
                  else                 do_shift = 1'b1;
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         idx_cnt     <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_idx      <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_abort <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_start <= do_start;
         frame_end   <= do_end;
         frame_abort <= do_end && (bit_cnt != 3'd0);

         if (do_start) begin
            bit_cnt <= '0;
            idx_cnt <= '0;
         end

         if (do_rx) begin
            rx_shift <= {rx_shift[6:0], mosi_lvl};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data  <= {rx_shift[6:0], mosi_lvl};
               rx_valid <= 1'b1;
               rx_idx   <= idx_cnt;
               if (idx_cnt != '1) idx_cnt <= idx_cnt + 1'b1;
            end
         end

         if (do_shift) tx_shift <= {tx_shift[6:0], 1'b0};

         // Load consumes the old holding contents; a same-cycle write
         // (only possible when empty) lands after the load.
         if (do_load) begin
            if (hold_full) begin
               tx_shift  <= hold_data;
               hold_full <= 1'b0;
            end else begin
               tx_shift    <= DEFAULT_TX;
               tx_underrun <= 1'b1;
            end
         end

         if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end
      end
   end

   assign tx_ready  = ~hold_full;
   assign pico_miso = (state_q == ACTIVE) ? tx_shift[7] : 1'b0;

endmodule

// File: tb/tb_pico_spi_slave_rx.sv
// Directed self-checking bench for pico_spi_slave_rx (IDX_W=8, sck at clk/10).
module tb_pico_spi_slave_rx;
   import pico_spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pico_sck = 1'b0;
   logic       pico_cs = 1'b0;
   logic       pico_mosi = 1'b0;
   logic       pico_miso;
   spi_byte_t  rx_data;
   logic       rx_valid;
   logic [7:0] rx_idx;
   logic       frame_start, frame_end, frame_abort;
   spi_byte_t  tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_underrun;

   int n_checks = 0;
   int n_err    = 0;

   int n_start = 0;
   int n_end   = 0;
   int n_under = 0;
   logic last_abort = 1'b0;
   logic [7:0] rxq_data[$];
   logic [7:0] rxq_idx[$];

   pico_spi_slave_rx #(
      .SYNC_STAGES(2),
      .IDX_W(8),
      .DEFAULT_TX(8'hFF)
   ) dut (
      .clk(clk), .rst(rst),
      .pico_sck(pico_sck), .pico_cs(pico_cs), .pico_mosi(pico_mosi),
      .pico_miso(pico_miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_idx(rx_idx),
      .frame_start(frame_start), .frame_end(frame_end), .frame_abort(frame_abort),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rxq_data.push_back(rx_data);
         rxq_idx.push_back(rx_idx);
      end
      if (frame_start) n_start++;
      if (frame_end) begin
         n_end++;
         last_abort = frame_abort;
      end
      if (tx_underrun) n_under++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_start = 0;
      n_end = 0;
      n_under = 0;
      last_abort = 1'b0;
      rxq_data.delete();
      rxq_idx.delete();
   endtask

   // Mode 0: MOSI set while sck low, both sides sample on sck rise.
   task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] so);
      so = '0;
      for (int i = 0; i < nbits; i++) begin
         pico_mosi = b[7-i];
         #50;
         pico_sck = 1'b1;
         so = {so[6:0], pico_miso};
         #50;
         pico_sck = 1'b0;
      end
   endtask

   task automatic put_tx(input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      while (!tx_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!tx_ready) check("tx_ready_timeout", 32'd0, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] so;

      // 1: reset with cs low and sck toggling, released mid-frame
      rst = 1'b1;
      pico_cs = 1'b0;
      xfer(8'hC3, 8, so);
      check("rst_miso", pico_miso, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_idx", rx_idx, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_end", frame_end, 0);
      check("rst_underrun", tx_underrun, 0);
      clear_mon();
      #20 rst = 1'b0;
      xfer(8'h5A, 8, so);
      xfer(8'h0F, 8, so);
      #200;
      check("t1_no_start", n_start, 0);
      check("t1_no_rx", rxq_data.size(), 0);
      pico_cs = 1'b1;
      #200;
      pico_cs = 1'b0;
      #100;
      xfer(8'h5A, 8, so);
      #100 pico_cs = 1'b1;
      #200;
      check("t1_start", n_start, 1);
      check("t1_end", n_end, 1);
      check("t1_rx_cnt", rxq_data.size(), 1);
      if (rxq_data.size() == 1) begin
         check("t1_rx_data", rxq_data[0], 8'h5A);
         check("t1_rx_idx", rxq_idx[0], 0);
      end

      // 2: two-byte frame, no tx bytes supplied
      clear_mon();
      pico_cs = 1'b0;
      #100;
      xfer(8'hA5, 8, so);
      check("t2_miso0", so, 8'hFF);
      xfer(8'h3C, 8, so);
      check("t2_miso1", so, 8'hFF);
      #100 pico_cs = 1'b1;
      #200;
      check("t2_rx_cnt", rxq_data.size(), 2);
      if (rxq_data.size() == 2) begin
         check("t2_rx_data0", rxq_data[0], 8'hA5);
         check("t2_rx_idx0", rxq_idx[0], 0);
         check("t2_rx_data1", rxq_data[1], 8'h3C);
         check("t2_rx_idx1", rxq_idx[1], 1);
      end
      check("t2_start", n_start, 1);
      check("t2_end", n_end, 1);
      check("t2_abort", last_abort, 0);
      check("t2_underruns", n_under, 3);

      // 3: pre-loaded response then underrun
      clear_mon();
      put_tx(8'h9F);
      check("t3_ready_full", tx_ready, 0);
      pico_cs = 1'b0;
      put_tx(8'h01);
      #50;
      xfer(8'h00, 8, so);
      check("t3_miso0", so, 8'h9F);
      xfer(8'h00, 8, so);
      check("t3_miso1", so, 8'h01);
      xfer(8'h00, 8, so);
      check("t3_miso2", so, 8'hFF);
      #100 pico_cs = 1'b1;
      #200;
      check("t3_underruns", n_under, 2);
      check("t3_ready_idle", tx_ready, 1);
      check("t3_rx_cnt", rxq_data.size(), 3);

      // 4: cs rises after 5 bits
      clear_mon();
      pico_cs = 1'b0;
      #100;
      xfer(8'hFF, 5, so);
      #100 pico_cs = 1'b1;
      #200;
      check("t4_end", n_end, 1);
      check("t4_abort", last_abort, 1);
      check("t4_no_rx", rxq_data.size(), 0);
      clear_mon();
      pico_cs = 1'b0;
      #100;
      xfer(8'h77, 8, so);
      #100 pico_cs = 1'b1;
      #200;
      check("t4_next_cnt", rxq_data.size(), 1);
      if (rxq_data.size() == 1) begin
         check("t4_next_data", rxq_data[0], 8'h77);
         check("t4_next_idx", rxq_idx[0], 0);
      end
      check("t4_next_abort", last_abort, 0);

      // 5: async reset during byte 2
      clear_mon();
      pico_cs = 1'b0;
      #100;
      xfer(8'h11, 8, so);
      xfer(8'hE0, 3, so);
      put_tx(8'hCD);
      check("t5_ready_full", tx_ready, 0);
      check("t5_rx_before", rxq_data.size(), 1);
      #3 rst = 1'b1;
      #1;
      check("t5_rst_miso", pico_miso, 0);
      check("t5_rst_valid", rx_valid, 0);
      check("t5_rst_data", rx_data, 0);
      check("t5_rst_idx", rx_idx, 0);
      check("t5_rst_ready", tx_ready, 1);
      #50 rst = 1'b0;
      #200;
      clear_mon();
      pico_cs = 1'b1;
      #200;
      pico_cs = 1'b0;
      #100;
      xfer(8'h22, 8, so);
      #100 pico_cs = 1'b1;
      #200;
      check("t5_new_cnt", rxq_data.size(), 1);
      if (rxq_data.size() == 1) begin
         check("t5_new_data", rxq_data[0], 8'h22);
         check("t5_new_idx", rxq_idx[0], 0);
      end

      // 6: 260-byte frame, index saturates at 255
      clear_mon();
      pico_cs = 1'b0;
      #100;
      for (int i = 0; i < 260; i++) begin
         logic [7:0] b;
         b = 8'(i * 7 + 3);
         xfer(b, 8, so);
      end
      #100 pico_cs = 1'b1;
      #200;
      check("t6_rx_cnt", rxq_data.size(), 260);
      for (int i = 0; i < 260 && i < rxq_data.size(); i++) begin
         logic [7:0] eb;
         eb = 8'(i * 7 + 3);
         check($sformatf("t6_data%0d", i), rxq_data[i], eb);
         check($sformatf("t6_idx%0d", i), rxq_idx[i], (i > 255) ? 255 : i);
      end
      check("t6_abort", last_abort, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
